bp_btb: RTL and testbench

Parametrised branch prediction unit with a direct-mapped branch target buffer. It replaces the single-bit prediction in the fetch stage. The fetch stage queries it combinationally with the current PC and receives a taken/not-taken prediction plus the next fetch address. The ID/hazard logic writes resolved branch outcomes back into it. Each entry holds a saturating counter of parametrised width; the block also keeps lookup and misprediction statistics.

---
 rtl/bp_btb.sv | 100 ++++++++++
 tb/tb_bp_btb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with saturating direction counters and update statistics.
// Lookup is combinational; updates and flushes take effect on the next rising edge.
module bp_btb #(
  parameter int DATA_W  = 16,
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] pc_i,
  output logic              hit_o,
  output logic              predtaken_o,
  output logic [DATA_W-1:0] predtarget_o,
  input  logic              update_i,
  input  logic [DATA_W-1:0] update_pc_i,
  input  logic              update_taken_i,
  input  logic [DATA_W-1:0] update_target_i,
  input  logic              update_mispred_i,
  input  logic              flush_i,
  output logic [STAT_W-1:0] stat_lookups_o,
  output logic [STAT_W-1:0] stat_mispred_o
);
  localparam int TAG_W = DATA_W - IDX_W;
  localparam logic [CTR_W-1:0] WNT = CTR_W'((2 ** (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] WT  = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [CTR_W-1:0] MAX = {CTR_W{1'b1}};

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [DATA_W-1:0] tgt_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];
  logic [STAT_W-1:0] lookups_q, lookups_d;
  logic [STAT_W-1:0] mispred_q, mispred_d;

  logic [IDX_W-1:0]  idx, uidx;
  logic [TAG_W-1:0]  ptag, utag;
  logic              uhit, accept, wr_en;
  logic [CTR_W-1:0]  uctr, ctr_d;
  logic [DATA_W-1:0] tgt_d;

  assign idx          = pc_i[IDX_W-1:0];
  assign ptag         = pc_i[DATA_W-1:IDX_W];
  assign hit_o        = valid_q[idx] && (tag_q[idx] == ptag);
  assign predtaken_o  = hit_o && ctr_q[idx][CTR_W-1];
  assign predtarget_o = predtaken_o ? tgt_q[idx] : pc_i + DATA_W'(1);

  assign uidx   = update_pc_i[IDX_W-1:0];
  assign utag   = update_pc_i[DATA_W-1:IDX_W];
  assign uctr   = ctr_q[uidx];
  assign uhit   = valid_q[uidx] && (tag_q[uidx] == utag);
  assign accept = update_i && !flush_i;
  // A not-taken miss leaves the table alone; everything else writes the indexed entry.
  assign wr_en  = accept && (uhit || update_taken_i);

  always_comb begin
    ctr_d = WT;
    if (uhit) begin
      if (update_taken_i) ctr_d = (uctr == MAX) ? MAX : uctr + CTR_W'(1);
      else                ctr_d = (uctr == '0) ? '0 : uctr - CTR_W'(1);
    end
    tgt_d = update_taken_i ? update_target_i : tgt_q[uidx];
  end

  always_comb begin
    lookups_d = lookups_q;
    mispred_d = mispred_q;
    if (accept && lookups_q != {STAT_W{1'b1}}) lookups_d = lookups_q + STAT_W'(1);
    if (accept && update_mispred_i && mispred_q != {STAT_W{1'b1}})
      mispred_d = mispred_q + STAT_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= WNT;
      end
      lookups_q <= '0;
      mispred_q <= '0;
    end else begin
      if (flush_i) begin
        for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
      end else if (wr_en) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
        tgt_q[uidx]   <= tgt_d;
        ctr_q[uidx]   <= ctr_d;
      end
      lookups_q <= lookups_d;
      mispred_q <= mispred_d;
    end
  end

  assign stat_lookups_o = lookups_q;
  assign stat_mispred_o = mispred_q;
endmodule

// File: tb/tb_bp_btb.sv
// Directed and randomized checks of bp_btb against an array-based reference model.
module tb_bp_btb;
  localparam int DW = 16, NE = 16, IW = 4, CW = 2, SW = 4;
  localparam int CMAX = 3, CWT = 2, CWNT = 1, SMAX = 15;

  logic          CLK = 1'b0, RST = 1'b1;
  logic [DW-1:0] pc_i = '0, update_pc_i = '0, update_target_i = '0, predtarget_o;
  logic          update_i = 1'b0, update_taken_i = 1'b0, update_mispred_i = 1'b0, flush_i = 1'b0;
  logic          hit_o, predtaken_o;
  logic [SW-1:0] stat_lookups_o, stat_mispred_o;

  bp_btb #(.DATA_W(DW), .ENTRIES(NE), .IDX_W(IW), .CTR_W(CW), .STAT_W(SW)) dut (
    .CLK(CLK), .RST(RST), .pc_i(pc_i), .hit_o(hit_o), .predtaken_o(predtaken_o),
    .predtarget_o(predtarget_o), .update_i(update_i), .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i), .update_target_i(update_target_i),
    .update_mispred_i(update_mispred_i), .flush_i(flush_i),
    .stat_lookups_o(stat_lookups_o), .stat_mispred_o(stat_mispred_o));

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  bit m_valid [NE];
  int m_tag [NE], m_tgt [NE], m_ctr [NE];
  int m_look, m_mis;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NE; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = CWNT;
    end
    m_look = 0; m_mis = 0;
  endtask

  task automatic check_model(input string nm);
    int p, i;
    bit h, t;
    int tg;
    p  = int'(pc_i);
    i  = p % NE;
    h  = m_valid[i] && m_tag[i] == p / NE;
    t  = h && m_ctr[i] >= CWT;
    tg = t ? m_tgt[i] : (p + 1) % 65536;
    chk({nm, "_hit"}, 32'(hit_o), 32'(h));
    chk({nm, "_ptk"}, 32'(predtaken_o), 32'(t));
    chk({nm, "_ptg"}, 32'(predtarget_o), 32'(tg));
    chk({nm, "_slk"}, 32'(stat_lookups_o), 32'(m_look));
    chk({nm, "_smp"}, 32'(stat_mispred_o), 32'(m_mis));
  endtask

  task automatic m_update(input bit upd, input int upc, input bit ut, input int utgt,
                          input bit um, input bit fl);
    int i;
    bit h;
    if (fl) begin
      for (int k = 0; k < NE; k++) m_valid[k] = 0;
      return;
    end
    if (!upd) return;
    m_look = (m_look < SMAX) ? m_look + 1 : SMAX;
    if (um) m_mis = (m_mis < SMAX) ? m_mis + 1 : SMAX;
    i = upc % NE;
    h = m_valid[i] && m_tag[i] == upc / NE;
    if (h && ut) begin
      m_ctr[i] = (m_ctr[i] + 1 > CMAX) ? CMAX : m_ctr[i] + 1;
      m_tgt[i] = utgt;
    end else if (h) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (ut) begin
      m_valid[i] = 1; m_tag[i] = upc / NE; m_tgt[i] = utgt; m_ctr[i] = CWT;
    end
  endtask

  // Drive one cycle: check the pre-edge lookup against the model, then clock and update the model.
  task automatic step(input string nm, input int pc, input bit upd, input int upc, input bit ut,
                      input int utgt, input bit um, input bit fl);
    pc_i = DW'(pc); update_i = upd; update_pc_i = DW'(upc); update_taken_i = ut;
    update_target_i = DW'(utgt); update_mispred_i = um; flush_i = fl;
    #2;
    check_model(nm);
    @(posedge CLK);
    m_update(upd, upc, ut, utgt, um, fl);
    #1;
    update_i = 0; flush_i = 0; update_mispred_i = 0;
  endtask

  task automatic look(input int pc);
    pc_i = DW'(pc); update_i = 0; flush_i = 0;
    #2;
  endtask

  initial begin
    int pc, upc;
    m_reset();
    #12 RST = 1'b0;
    @(posedge CLK); #1;

    look(16'h0020);
    chk("rst_hit", 32'(hit_o), 0);
    chk("rst_ptk", 32'(predtaken_o), 0);
    chk("rst_ptg", 32'(predtarget_o), 32'h21);
    chk("rst_slk", 32'(stat_lookups_o), 0);
    chk("rst_smp", 32'(stat_mispred_o), 0);
    look(16'hFFFF);
    chk("wrap_ptg", 32'(predtarget_o), 32'h0);

    step("alloc", 16'h0020, 1, 16'h0020, 1, 16'h0040, 0, 0);
    look(16'h0020);
    chk("alloc_hit", 32'(hit_o), 1);
    chk("alloc_ptk", 32'(predtaken_o), 1);
    chk("alloc_ptg", 32'(predtarget_o), 32'h40);
    chk("alloc_slk", 32'(stat_lookups_o), 1);

    step("nt1", 16'h0020, 1, 16'h0020, 0, 0, 0, 0);
    look(16'h0020);
    chk("nt1_ptk", 32'(predtaken_o), 0);
    chk("nt1_ptg", 32'(predtarget_o), 32'h21);
    step("nt2", 16'h0020, 1, 16'h0020, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step("tk", 16'h0020, 1, 16'h0020, 1, 16'h0040, 0, 0);
      look(16'h0020);
      chk("walk_ptk", 32'(predtaken_o), (k >= 1) ? 1 : 0);
    end
    // Saturated at MAX: one not-taken leaves it predicting taken.
    step("sat_nt", 16'h0020, 1, 16'h0020, 0, 0, 0, 0);
    look(16'h0020);
    chk("sat_ptk", 32'(predtaken_o), 1);
    step("miss_nt", 16'h0050, 1, 16'h0050, 0, 0, 0, 0);
    look(16'h0050);
    chk("miss_nt_hit", 32'(hit_o), 0);

    step("alias", 16'h0030, 1, 16'h0030, 1, 16'h0060, 0, 0);
    look(16'h0030);
    chk("alias_hit", 32'(hit_o), 1);
    chk("alias_ptg", 32'(predtarget_o), 32'h60);
    look(16'h0020);
    chk("alias_old_hit", 32'(hit_o), 0);
    look(16'h0030);
    chk("same_pre_ptk", 32'(predtaken_o), 1);
    step("same", 16'h0030, 1, 16'h0030, 0, 0, 0, 0);
    look(16'h0030);
    chk("same_post_ptk", 32'(predtaken_o), 0);

    step("flush", 16'h0030, 1, 16'h0030, 1, 16'h0070, 1, 1);
    look(16'h0030);
    chk("flush_hit", 32'(hit_o), 0);
    chk("flush_slk", 32'(stat_lookups_o), 11);
    chk("flush_smp", 32'(stat_mispred_o), 0);
    step("realloc", 16'h0020, 1, 16'h0020, 1, 16'h0044, 0, 0);
    look(16'h0020);
    chk("realloc_ptk", 32'(predtaken_o), 1);
    chk("realloc_ptg", 32'(predtarget_o), 32'h44);

    for (int k = 0; k < 20; k++) step("satstat", 16'h0020, 1, 16'h0020, 1, 16'h0044, 1, 0);
    look(16'h0020);
    chk("sat_slk", 32'(stat_lookups_o), 32'hF);
    chk("sat_smp", 32'(stat_mispred_o), 32'hF);
    chk("pre_rst_hit", 32'(hit_o), 1);
    #1 RST = 1'b1;
    #1;
    chk("arst_hit", 32'(hit_o), 0);
    chk("arst_ptk", 32'(predtaken_o), 0);
    chk("arst_ptg", 32'(predtarget_o), 32'h21);
    chk("arst_slk", 32'(stat_lookups_o), 0);
    chk("arst_smp", 32'(stat_mispred_o), 0);
    m_reset();
    #1 RST = 1'b0;
    @(posedge CLK); #1;

    for (int k = 0; k < 400; k++) begin
      upc = $urandom_range(0, 3) * NE + $urandom_range(0, NE - 1);
      pc  = ($urandom_range(0, 3) == 0) ? upc : $urandom_range(0, 3) * NE + $urandom_range(0, NE - 1);
      if ($urandom_range(0, 30) == 0) pc = 16'hFFFF;
      step("rnd", pc, $urandom_range(0, 9) < 7, upc, $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 65535)), $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
